key_rate_sequencer: RTL
=======================

# key_rate_sequencer

Front-end sequencer that drives the blink-rate delay controller from the two DE1-SoC push buttons. Synchronizes and debounces the raw active-low KEY inputs, arbitrates between the "faster" and "slower" buttons, and issues one-cycle `faster`/`slower` step pulses with typematic auto-repeat while a button is held. Sits between the board KEY pins and the delay controller's `faster`/`slower` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronized input must differ from its debounced state before the state flips (20 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, default 25_000_000: cycles from the first step pulse to the first repeat pulse; minimum 2.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent repeat pulses; minimum 2.
- `CNT_W`, default 25: width of the debounce and repeat counters; must hold the largest of the three counts.

- `clk` in 1: system clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `key_faster_n` in 1: raw button, active-low, asynchronous to `clk`.
- `key_slower_n` in 1: raw button, active-low, asynchronous to `clk`.
- `faster` out 1: one-cycle step pulse toward shorter delay.
- `slower` out 1: one-cycle step pulse toward longer delay.
- `held` out 2: debounced pressed state, [1]=slower, [0]=faster, active-high.

## Operation
- Reset: `faster`=0, `slower`=0, `held`=2'b00, synchronizer flops=1 (released), debounce and repeat counters=0, FSM=IDLE.
- Synchronizer: two flops per key, then inverted to active-high `s_f`, `s_s`.
- Debounce (per key, independent): if synced value equals debounced state, counter=0; else counter increments; when counter==DEBOUNCE_CYCLES-1 and value still differs, debounced state takes synced value and counter=0. A single-cycle return to equality clears the counter.
- `held` is the debounced state, registered.
- Press event = debounced state 0->1 this cycle; release = 1->0.
- FSM states: IDLE, HOLD_F, HOLD_S, LOCKOUT.
  - IDLE: press on exactly one key -> emit that key's pulse next cycle, load repeat counter with REPEAT_DELAY-1, go HOLD_F/HOLD_S. Press on both keys same cycle -> LOCKOUT, no pulse.
  - HOLD_x: repeat counter decrements each cycle; at 0 with owner still held, emit owner pulse, reload REPEAT_PERIOD-1. Other key's press ignored. Owner release -> IDLE, counter=0, no pulse that cycle (release wins over a coincident repeat expiry).
  - LOCKOUT: no pulses; leave to IDLE only when both debounced states are 0.
  - From IDLE, a key still held from an earlier ownership produces no pulse; only a fresh press event starts a sequence.
- `faster` and `slower` are never high in the same cycle and are never high for two consecutive cycles.
- No knowledge of delay range limits; saturation is the delay controller's job.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- Raw press to `held` bit high: 2 (sync) + DEBOUNCE_CYCLES cycles after the first edge where the raw input is low, assuming no bounce.
- Debounced press to first pulse: 1 cycle (pulse in the cycle after `held` rises).
- First pulse to first repeat pulse: exactly REPEAT_DELAY cycles; subsequent repeats every REPEAT_PERIOD cycles.
- Release: `held` falls 2+DEBOUNCE_CYCLES after raw release; no pulse in or after that cycle.
- Reset asserted mid-hold: outputs 0 immediately (asynchronously); after deassertion a still-held key must re-debounce (from released) and then produces a fresh first pulse.

## Test plan
Parameters for bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press of key_faster_n held 6 cycles then released -> `held[0]` rises 6 cycles after raw low, exactly one `faster` pulse one cycle later, `slower` never pulses.
- key_slower_n bouncing (low 2, high 1, low 2, high 1) then steady low -> no `held[1]` change until 4 stable synced cycles; exactly one `slower` pulse.
- key_faster_n held 30 cycles post-debounce -> `faster` pulses at relative cycles 0, 10, 13, 16, 19, 22, 25, 28; stops on release.
- Both keys pressed on the same clock -> LOCKOUT, zero pulses; release one key -> still zero pulses; release both, press slower -> one `slower` pulse.
- Hold faster (pulsing), press slower mid-hold -> slower ignored; release faster -> no `slower` pulse while slower remains held.
- Assert reset during REPEAT with key held -> `faster`=0, `held`=0 at once; deassert -> `held[0]` rises after 6 cycles, fresh first pulse follows, then repeats at +10.

Source files
------------

// File: rtl/key_rate_sequencer_if.sv
// Board-side key inputs and step-pulse outputs of the key rate sequencer.
// master = board/driver side, slave = sequencer side.
interface key_rate_sequencer_if;
  logic       key_faster_n;
  logic       key_slower_n;
  logic       faster;
  logic       slower;
  logic [1:0] held;

  modport master (
    output key_faster_n,
    output key_slower_n,
    input  faster,
    input  slower,
    input  held
  );

  modport slave (
    input  key_faster_n,
    input  key_slower_n,
    output faster,
    output slower,
    output held
  );
endinterface

// File: rtl/key_rate_sequencer.sv
// Synchronizes and debounces the two rate keys, then issues faster/slower
// step pulses with typematic auto-repeat for the blink-delay controller.
module key_rate_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int CNT_W           = 25
) (
  input logic                 clk,
  input logic                 reset,
  key_rate_sequencer_if.slave seq_if
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  // IDLE: wait for press | HOLD_F/HOLD_S: repeat for owner | LOCKOUT: both pressed
  typedef enum logic [1:0] {IDLE, HOLD_F, HOLD_S, LOCKOUT} state_e;

  logic [1:0]            sync1_q, sync2_q, synced;
  logic [1:0]            db_q, db_d, prev_q, press;
  logic [1:0][CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  state_e                state_q, state_d;
  logic                  faster_q, faster_d, slower_q, slower_d;

  // bit 0 = faster key, bit 1 = slower key throughout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {seq_if.key_slower_n, seq_if.key_faster_n};
      sync2_q <= sync1_q;
    end
  end

  assign synced = ~sync2_q;

  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (synced[i] != db_q[i]) begin
        if (dcnt_q[i] == DB_LAST) db_d[i] = synced[i];
        else                      dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q   <= 2'b00;
      prev_q <= 2'b00;
      dcnt_q <= '0;
    end else begin
      db_q   <= db_d;
      prev_q <= db_q;
      dcnt_q <= dcnt_d;
    end
  end

  assign press = db_q & ~prev_q;

  // Ownership checks use db_d so a release beats a coincident repeat expiry.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    faster_d = 1'b0;
    slower_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press == 2'b11) begin
          state_d = LOCKOUT;
        end else if (press[0]) begin
          state_d  = HOLD_F;
          faster_d = 1'b1;
          rcnt_d   = DLY_LOAD;
        end else if (press[1]) begin
          state_d  = HOLD_S;
          slower_d = 1'b1;
          rcnt_d   = DLY_LOAD;
        end
      end
      HOLD_F: begin
        if (!db_d[0]) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == '0) begin
          faster_d = 1'b1;
          rcnt_d   = PER_LOAD;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      HOLD_S: begin
        if (!db_d[1]) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == '0) begin
          slower_d = 1'b1;
          rcnt_d   = PER_LOAD;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      LOCKOUT: begin
        if (db_d == 2'b00) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      faster_q <= 1'b0;
      slower_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      faster_q <= faster_d;
      slower_q <= slower_d;
    end
  end

  assign seq_if.faster = faster_q;
  assign seq_if.slower = slower_q;
  assign seq_if.held   = db_q;

endmodule
